// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 controller types and constants.
package sha256_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam int SHA_ROUNDS    = 64;
    localparam int W_LOAD_ROUNDS = 16;

    // H0 at index 0
    localparam logic [0:7][31:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_round_cnt.sv
// sha256_round_cnt: 6-bit round counter with clear/enable and terminal-count flag.
module sha256_round_cnt
    import sha256_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [5:0] cnt_o,
    output logic       tc_o
);

    logic [5:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? 6'd0 : en_i ? cnt_q + 6'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= 6'd0;
        else     cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
    assign tc_o  = cnt_q == 6'(SHA_ROUNDS - 1);

endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: sequences init, 64 rounds and hash update per block, with digest handshake.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int KLAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blk_valid,
    input  logic       blk_first,
    input  logic       blk_last,
    output logic       blk_ready,
    output logic [5:0] round,
    output logic       w_load,
    output logic       ld_iv,
    output logic       ld_work,
    output logic       rnd_en,
    output logic       upd_hash,
    output logic       busy,
    output logic       digest_valid,
    input  logic       digest_ready
);

    state_t     state_q, state_d;
    logic       first_q, first_d;
    logic       last_q, last_d;
    logic [5:0] rcnt;
    logic       rcnt_tc;
    logic       accept;
    logic       in_init, in_round, w_win;

    assign accept   = blk_valid && state_q == S_IDLE;
    assign in_init  = state_q == S_INIT;
    assign in_round = state_q == S_ROUND;

    sha256_round_cnt u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (in_init),
        .en_i  (in_round),
        .cnt_o (rcnt),
        .tc_o  (rcnt_tc)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
        end

    always_comb begin
        state_d = state_q;
        first_d = accept ? blk_first : first_q;
        last_d  = accept ? blk_last : last_q;
        case (state_q)
            S_IDLE:  state_d = blk_valid ? S_INIT : S_IDLE;
            S_INIT:  state_d = S_ROUND;
            S_ROUND: state_d = rcnt_tc ? S_FINAL : S_ROUND;
            S_FINAL: state_d = last_q ? S_DONE : S_IDLE;
            S_DONE:  state_d = digest_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // With KLAT=1 the index runs one ahead so K and W arrive with rnd_en; it holds 63 on the last round.
    always_comb begin
        blk_ready    = state_q == S_IDLE;
        busy         = state_q != S_IDLE;
        ld_work      = in_init;
        ld_iv        = in_init && first_q;
        rnd_en       = in_round;
        upd_hash     = state_q == S_FINAL;
        digest_valid = state_q == S_DONE;
        round        = !in_round ? 6'd0 : (KLAT == 0 || rcnt_tc) ? rcnt : rcnt + 6'd1;
        w_win        = in_round || (KLAT != 0 && in_init);
        w_load       = w_win && round < 6'(W_LOAD_ROUNDS);
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: randomized checks of both KLAT variants against a block-phase reference model.
module tb_sha256_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic blk_valid = 1'b0, blk_first = 1'b0, blk_last = 1'b0, digest_ready = 1'b0;
    logic [1:0] blk_ready, w_load, ld_iv, ld_work, rnd_en, upd_hash, busy, digest_valid;
    logic [5:0] round0, round1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cycles since accept (1 = init, 2..65 = rounds, 66 = final) plus a done flag.
    int m_off = 0;
    bit m_done = 0, m_first = 0, m_last = 0;

    always #5 clk = ~clk;

    sha256_round_ctrl u_dut0 (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_first(blk_first), .blk_last(blk_last),
        .blk_ready(blk_ready[0]), .round(round0), .w_load(w_load[0]), .ld_iv(ld_iv[0]),
        .ld_work(ld_work[0]), .rnd_en(rnd_en[0]), .upd_hash(upd_hash[0]), .busy(busy[0]),
        .digest_valid(digest_valid[0]), .digest_ready(digest_ready)
    );

    sha256_round_ctrl #(.KLAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_first(blk_first), .blk_last(blk_last),
        .blk_ready(blk_ready[1]), .round(round1), .w_load(w_load[1]), .ld_iv(ld_iv[1]),
        .ld_work(ld_work[1]), .rnd_en(rnd_en[1]), .upd_hash(upd_hash[1]), .busy(busy[1]),
        .digest_valid(digest_valid[1]), .digest_ready(digest_ready)
    );

    function automatic logic [13:0] obs(int k);
        return {blk_ready[k], busy[k], ld_iv[k], ld_work[k], rnd_en[k], upd_hash[k],
                digest_valid[k], w_load[k], k == 0 ? round0 : round1};
    endfunction

    function automatic logic [13:0] exp_vec(bit klat);
        int idx;
        bit win;
        idx = 0;
        win = 0;
        if (m_done) return {1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 6'd0};
        if (m_off == 0) return {1'b1, 13'd0};
        if (m_off == 1) win = klat;
        else if (m_off <= 65) begin
            win = 1;
            idx = klat ? ((m_off - 1 > 63) ? 63 : m_off - 1) : m_off - 2;
        end
        return {1'b0, 1'b1, m_off == 1 && m_first, m_off == 1, m_off >= 2 && m_off <= 65,
                m_off == 66, 1'b0, win && idx < 16, 6'(idx)};
    endfunction

    task automatic model_reset();
        m_off = 0;
        m_done = 0;
        m_first = 0;
        m_last = 0;
    endtask

    task automatic step(input bit v, input bit f, input bit l, input bit r);
        blk_valid = v;
        blk_first = f;
        blk_last = l;
        digest_ready = r;
        if (m_done) m_done = !r;
        else if (m_off == 0) begin
            if (v) begin
                m_off = 1;
                m_first = f;
                m_last = l;
            end
        end else if (m_off < 66) m_off++;
        else begin
            m_off = 0;
            m_done = m_last;
        end
        @(posedge clk);
        #1;
    endtask

    // Protocol checker: control strobes never overlap; each block has exactly 64 rounds.
    int rnd_seen = 0;
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (!$onehot0({ld_iv[k] | ld_work[k], rnd_en[k], upd_hash[k]}) || (ld_iv[k] && !ld_work[k])) begin
                    n_bad++;
                    $display("FAIL onehot dut%0d: got iv=%b work=%b rnd=%b upd=%b, required at most one", k,
                             ld_iv[k], ld_work[k], rnd_en[k], upd_hash[k]);
                end
            end
            if (ld_work[0]) rnd_seen = 0;
            if (rnd_en[0]) rnd_seen++;
            if (upd_hash[0]) begin
                n_cmp++;
                if (rnd_seen != 64) begin
                    n_bad++;
                    $display("FAIL round_count: got %0d rnd_en cycles, required 64", rnd_seen);
                end
            end
        end else rnd_seen = 0;
    end

    task automatic test_reset();
        rst = 1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== exp_vec(1'(k))) begin
                n_bad++;
                $display("FAIL reset dut%0d: got %h, required %h", k, obs(k), exp_vec(1'(k)));
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single_block();
        step(1, 1, 1, 1);
        for (int c = 1; c <= 70; c++) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== exp_vec(1'(k))) begin
                    n_bad++;
                    $display("FAIL single c=%0d dut%0d: got %h, required %h", c, k, obs(k), exp_vec(1'(k)));
                end
            end
            step(c < 64 ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom), 1'($urandom), 1'b1);
        end
    endtask

    task automatic test_two_block();
        int blocks;
        blocks = 0;
        step(1, 1, 0, 0);
        for (int c = 1; c <= 140; c++) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== exp_vec(1'(k))) begin
                    n_bad++;
                    $display("FAIL two_block c=%0d dut%0d: got %h, required %h", c, k, obs(k), exp_vec(1'(k)));
                end
            end
            if (m_off == 66 && blocks == 0) begin
                blocks = 1;
                step(1, 0, 1, 0);
            end else step(blocks == 1 && m_off == 0 && !m_done, 0, 1, 1);
            if (m_off == 1) blocks = 2;
        end
    endtask

    task automatic test_back_pressure();
        step(1, 1, 1, 0);
        while (!m_done) step(1'($urandom_range(0, 1)) && m_off != 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== exp_vec(1'(k))) begin
                    n_bad++;
                    $display("FAIL backpressure c=%0d dut%0d: got %h, required %h", c, k, obs(k), exp_vec(1'(k)));
                end
            end
            step(1, 1, 1, 0);
        end
        step(0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== exp_vec(1'(k))) begin
                n_bad++;
                $display("FAIL release dut%0d: got %h, required %h", k, obs(k), exp_vec(1'(k)));
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0);
        while (m_off != 32) step(0, 0, 0, 0);
        #1 rst = 1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== exp_vec(1'(k))) begin
                n_bad++;
                $display("FAIL async_reset dut%0d: got %h, required %h", k, obs(k), exp_vec(1'(k)));
            end
        end
        @(negedge clk);
        rst = 0;
        step(1, 0, 0, 0);
        for (int c = 1; c <= 68; c++) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== exp_vec(1'(k))) begin
                    n_bad++;
                    $display("FAIL after_reset c=%0d dut%0d: got %h, required %h", c, k, obs(k), exp_vec(1'(k)));
                end
            end
            step(0, 0, 0, 0);
        end
    endtask

    task automatic test_stress();
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== exp_vec(1'(k))) begin
                    n_bad++;
                    $display("FAIL stress c=%0d dut%0d: got %h, required %h", c, k, obs(k), exp_vec(1'(k)));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_two_block();
        test_back_pressure();
        test_reset_mid();
        test_stress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
